// File: rtl/clk_reset_sequencer_pkg.sv
// clk_mgmt_pkg: shared state encoding, default sequencer timing and saturating increment
package clk_mgmt_pkg;
    typedef enum logic [1:0] {S_MMCM_RST, S_WAIT_LOCK, S_RELEASE, S_RUN} state_e;
    localparam int DEF_NUM_DOMAINS = 3;
    localparam int DEF_MMCM_RST_CYCLES = 8;
    localparam int DEF_LOCK_STABLE = 16;
    localparam int DEF_LOCK_TIMEOUT = 1000;
    localparam int DEF_STAGE_DELAY = 4;
    localparam int DEF_CNT_W = 8;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] lim;
        lim = (32'd1 << w) - 32'd1;
        return (v >= lim) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/clk_reset_sequencer_bit_sync.sv
// bit_sync: two-flop synchroniser for a single asynchronous level
module bit_sync (
    input  logic Clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [1:0] ff;
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else ff <= {ff[0], d};
    end
    assign q = ff[1];
endmodule

// File: rtl/clk_reset_sequencer.sv
// clk_reset_sequencer: MMCM reset, lock qualification and ordered per-domain reset release
module clk_reset_sequencer
    import clk_mgmt_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   Clk,
    input  logic                   rst_n,
    input  logic                   mmcm_locked,
    input  logic                   soft_reset_req,
    output logic                   mmcm_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   clk_good,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    output logic [CNT_W-1:0]       retry_cnt
);
    localparam int CW = $clog2(LOCK_TIMEOUT + MMCM_RST_CYCLES + STAGE_DELAY + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    state_e                 state;
    logic [CW-1:0]          cyc;
    logic [SW-1:0]          stable;
    logic                   locked_s;
    logic [NUM_DOMAINS-1:0] dom_next;
    bit_sync u_sync (
        .Clk  (Clk),
        .rst_n(rst_n),
        .d    (mmcm_locked),
        .q    (locked_s)
    );
    // releases shift in from bit 0 so domains come up strictly in index order
    assign dom_next = NUM_DOMAINS'({domain_rst_n, 1'b1});
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_MMCM_RST;
            mmcm_rst      <= 1'b1;
            domain_rst_n  <= '0;
            clk_good      <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
            cyc           <= '0;
            stable        <= '0;
        end else begin
            case (state)
                S_MMCM_RST: begin
                    if (cyc == CW'(MMCM_RST_CYCLES - 1)) begin
                        state    <= S_WAIT_LOCK;
                        mmcm_rst <= 1'b0;
                        cyc      <= '0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    stable <= locked_s ? stable + 1'b1 : '0;
                    cyc    <= cyc + 1'b1;
                    if (locked_s && stable == SW'(LOCK_STABLE - 1)) begin
                        state  <= S_RELEASE;
                        cyc    <= '0;
                        stable <= '0;
                    end else if (cyc == CW'(LOCK_TIMEOUT - 1)) begin
                        state     <= S_MMCM_RST;
                        mmcm_rst  <= 1'b1;
                        cyc       <= '0;
                        stable    <= '0;
                        retry_cnt <= CNT_W'(sat_inc(32'(retry_cnt), CNT_W));
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!locked_s) begin
                        state         <= S_MMCM_RST;
                        mmcm_rst      <= 1'b1;
                        domain_rst_n  <= '0;
                        clk_good      <= 1'b0;
                        cyc           <= '0;
                        lock_loss_cnt <= CNT_W'(sat_inc(32'(lock_loss_cnt), CNT_W));
                    end else if (state == S_RUN) begin
                        if (soft_reset_req) begin
                            state        <= S_RELEASE;
                            domain_rst_n <= '0;
                            clk_good     <= 1'b0;
                            cyc          <= '0;
                        end else begin
                            clk_good <= 1'b1;
                        end
                    end else if (cyc == CW'(STAGE_DELAY - 1)) begin
                        domain_rst_n <= dom_next;
                        cyc          <= '0;
                        if (&dom_next) state <= S_RUN;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb_clk_reset_sequencer: scoreboard of expected output-change events with their cycle stamps
module tb_clk_reset_sequencer;
    logic       Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       mmcm_rst;
    logic [2:0] domain_rst_n;
    logic       clk_good;
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_cnt;
    typedef struct {
        int          c;
        logic [20:0] v;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int llc = 0;
    int rc = 0;
    clk_reset_sequencer dut (
        .Clk           (Clk),
        .rst_n         (rst_n),
        .mmcm_locked   (mmcm_locked),
        .soft_reset_req(soft_reset_req),
        .mmcm_rst      (mmcm_rst),
        .domain_rst_n  (domain_rst_n),
        .clk_good      (clk_good),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    task automatic push(input int c, input logic m, input logic [2:0] d, input logic g);
        exp_t e;
        e.c = c;
        e.v = {m, d, g, 8'(llc), 8'(rc)};
        q.push_back(e);
    endtask
    task automatic wait_until(input int n);
        while (cyc < n) @(negedge Clk);
    endtask
    task automatic rel(input int b);
        push(b, 1'b0, 3'b001, 1'b0);
        push(b + 4, 1'b0, 3'b011, 1'b0);
        push(b + 8, 1'b0, 3'b111, 1'b0);
        push(b + 9, 1'b0, 3'b111, 1'b1);
    endtask
    task automatic drop_lock();
        int d;
        d = cyc;
        mmcm_locked = 1'b0;
        llc++;
        push(d + 3, 1'b1, 3'b000, 1'b0);
        push(d + 11, 1'b0, 3'b000, 1'b0);
        wait_until(d + 11);
    endtask
    // monitor: every change of the output bundle must match the next queued event
    initial begin
        logic [20:0] prev;
        logic [20:0] snap;
        exp_t e;
        prev = '1;
        #7;
        forever begin
            @(negedge Clk or negedge rst_n);
            #1;
            snap = {mmcm_rst, domain_rst_n, clk_good, lock_loss_cnt, retry_cnt};
            if (snap !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, snap);
                end else begin
                    e = q.pop_front();
                    if (snap !== e.v || (e.c >= 0 && e.c != cyc))
                        begin
                            errors++;
                            $display("FAIL event cyc=%0d got=%h want=%h at cyc %0d", cyc, snap, e.v, e.c);
                        end
                end
                prev = snap;
            end
        end
    end
    initial begin
        int c0, l, d, s, m;
        push(-1, 1'b1, 3'b000, 1'b0);
        repeat (3) @(negedge Clk);
        c0 = cyc;
        rst_n = 1'b1;
        push(c0 + 8, 1'b0, 3'b000, 1'b0);
        wait_until(c0 + 20);
        l = cyc;
        mmcm_locked = 1'b1;
        rel(l + 22);
        wait_until(l + 40);
        drop_lock();
        l = cyc;
        mmcm_locked = 1'b1;
        rel(l + 22);
        wait_until(l + 40);
        s = cyc;
        soft_reset_req = 1'b1;
        push(s + 1, 1'b0, 3'b000, 1'b0);
        @(negedge Clk);
        soft_reset_req = 1'b0;
        rel(s + 5);
        wait_until(s + 25);
        drop_lock();
        l = cyc;
        mmcm_locked = 1'b1;
        wait_until(l + 10);
        mmcm_locked = 1'b0;
        wait_until(l + 11);
        mmcm_locked = 1'b1;
        rel(l + 33);
        wait_until(l + 50);
        drop_lock();
        d = cyc - 11;
        rc = 1;
        push(d + 1011, 1'b1, 3'b000, 1'b0);
        push(d + 1019, 1'b0, 3'b000, 1'b0);
        rc = 2;
        push(d + 2019, 1'b1, 3'b000, 1'b0);
        push(d + 2027, 1'b0, 3'b000, 1'b0);
        wait_until(d + 2027);
        l = cyc;
        mmcm_locked = 1'b1;
        push(l + 22, 1'b0, 3'b001, 1'b0);
        push(l + 26, 1'b0, 3'b011, 1'b0);
        wait_until(l + 28);
        llc = 0;
        rc = 0;
        push(cyc, 1'b1, 3'b000, 1'b0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        m = cyc + 8;
        rst_n = 1'b1;
        push(m, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 256; i++) begin
            push(m + 20, 1'b0, 3'b001, 1'b0);
            wait_until(m + 20);
            mmcm_locked = 1'b0;
            wait_until(m + 21);
            mmcm_locked = 1'b1;
            if (llc < 255) llc++;
            push(m + 23, 1'b1, 3'b000, 1'b0);
            push(m + 31, 1'b0, 3'b000, 1'b0);
            wait_until(m + 31);
            m += 31;
        end
        repeat (20) @(negedge Clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
